// File: rtl/tick_pkg.sv
// Shared constants and state encodings for the tick generators and the period meter.
package tick_pkg;

    localparam int unsigned TICK_WIDTH = 30;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        ARM  = 2'b01,
        MEAS = 2'b10
    } meter_state_e;

endpackage

// File: rtl/sync_edge.sv
// Two-flop synchronizer plus a history flop; emits a one-cycle rising-edge pulse.
module sync_edge (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d_i,
    output logic rise_o
);

    logic [2:0] sync_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[1:0], d_i};
        end
    end

    assign rise_o = sync_q[1] & ~sync_q[2];

endmodule

// File: rtl/pulse_period_meter.sv
// Reports the number of clock cycles between consecutive rising edges of tick_i.
module pulse_period_meter
    import tick_pkg::*;
#(
    parameter int unsigned Width = TICK_WIDTH
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             en_i,
    input  logic             tick_i,
    output logic [Width-1:0] period_o,
    output logic             valid_o,
    output logic             ovf_o
);

    localparam logic [Width-1:0] CNT_MAX = '1;
    localparam logic [Width-1:0] CNT_ONE = Width'(1);

    meter_state_e     state_q, state_d;
    logic [Width-1:0] cnt_q, cnt_d;
    logic [Width-1:0] period_d;
    logic             valid_d, ovf_d;
    logic             rise;

    sync_edge u_sync_edge (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .d_i    (tick_i),
        .rise_o (rise)
    );

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        period_d = period_o;
        ovf_d    = ovf_o;
        valid_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (en_i) state_d = ARM;
            end
            ARM: begin
                if (!en_i) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (rise) begin
                    state_d = MEAS;
                    cnt_d   = CNT_ONE;
                end
            end
            MEAS: begin
                // Disable wins over a coincident edge; that edge is dropped.
                if (!en_i) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (rise) begin
                    period_d = cnt_q;
                    ovf_d    = (cnt_q == CNT_MAX);
                    valid_d  = 1'b1;
                    cnt_d    = CNT_ONE;
                end else if (cnt_q != CNT_MAX) begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            period_o <= '0;
            ovf_o    <= 1'b0;
            valid_o  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            period_o <= period_d;
            ovf_o    <= ovf_d;
            valid_o  <= valid_d;
        end
    end

endmodule

// File: tb/tb_pulse_period_meter.sv
// Randomized scoreboard bench: Width=30 and Width=4 meters share one stimulus stream.
module tb_pulse_period_meter;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        en_i = 1'b0;
    logic        tick_i = 1'b0;
    logic [29:0] period30;
    logic [3:0]  period4;
    logic        valid30, valid4, ovf30, ovf4;

    pulse_period_meter #(.Width(30)) u30 (
        .clk_i(clk_i), .rst_ni(rst_ni), .en_i(en_i), .tick_i(tick_i),
        .period_o(period30), .valid_o(valid30), .ovf_o(ovf30)
    );

    pulse_period_meter #(.Width(4)) u4 (
        .clk_i(clk_i), .rst_ni(rst_ni), .en_i(en_i), .tick_i(tick_i),
        .period_o(period4), .valid_o(valid4), .ovf_o(ovf4)
    );

    initial forever #5 clk_i = ~clk_i;

    typedef struct {
        int     cyc;
        longint p30;
        bit     o30;
        longint p4;
        bit     o4;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d (cycle %0d)", nm, act, req, cyc);
        end
    endtask

    // Reference model: a rising edge first sampled at clock m-2 is acted on at clock m.
    // An edge counts only if en_i was high at this clock and the previous one; the
    // period is the distance to the previous counted edge of the same enable run.
    initial begin
        logic [2:0] hist;
        bit         en_prev;
        int         last;
        hist = '0; en_prev = 0; last = -1;
        forever begin
            @(posedge clk_i);
            cyc++;
            if (!rst_ni) begin
                hist = '0; en_prev = 0; last = -1;
            end else begin
                if (!en_i) begin
                    last = -1;
                end else if (en_prev && hist[1] && !hist[2]) begin
                    if (last >= 0) begin
                        exp_t   e;
                        longint d, m30, m4;
                        d   = longint'(cyc - last);
                        m30 = (64'd1 << 30) - 1;
                        m4  = 15;
                        e.cyc = cyc;
                        e.p30 = (d >= m30) ? m30 : d;
                        e.o30 = (d >= m30);
                        e.p4  = (d >= m4) ? m4 : d;
                        e.o4  = (d >= m4);
                        q.push_back(e);
                    end
                    last = cyc;
                end
                en_prev = en_i;
                hist    = {hist[1:0], tick_i};
            end
        end
    end

    // Monitor: pops on every strobe, otherwise checks that outputs hold.
    initial begin
        longint h30, h4;
        bit     ho30, ho4, prev_v;
        h30 = 0; h4 = 0; ho30 = 0; ho4 = 0; prev_v = 0;
        forever begin
            @(negedge clk_i);
            if (!rst_ni) begin
                chk("rst_period30", 64'(period30), 0);
                chk("rst_period4", 64'(period4), 0);
                chk("rst_valid", 64'({valid30, valid4}), 0);
                chk("rst_ovf", 64'({ovf30, ovf4}), 0);
                h30 = 0; h4 = 0; ho30 = 0; ho4 = 0; prev_v = 0;
            end else begin
                while (q.size() > 0 && q[0].cyc < cyc) begin
                    chk("missed_strobe_cycle", 64'(cyc), 64'(q[0].cyc));
                    void'(q.pop_front());
                end
                if (valid30 || valid4) begin
                    chk("valid_pair", 64'(valid4), 64'(valid30));
                    chk("no_back_to_back", 64'(prev_v), 0);
                    if (q.size() == 0) begin
                        chk("unexpected_strobe", 1, 0);
                    end else begin
                        exp_t e;
                        e = q.pop_front();
                        chk("strobe_cycle", 64'(cyc), 64'(e.cyc));
                        chk("period30", 64'(period30), 64'(e.p30));
                        chk("ovf30", 64'(ovf30), 64'(e.o30));
                        chk("period4", 64'(period4), 64'(e.p4));
                        chk("ovf4", 64'(ovf4), 64'(e.o4));
                        h30 = e.p30; ho30 = e.o30; h4 = e.p4; ho4 = e.o4;
                    end
                end else begin
                    chk("hold_period30", 64'(period30), 64'(h30));
                    chk("hold_ovf30", 64'(ovf30), 64'(ho30));
                    chk("hold_period4", 64'(period4), 64'(h4));
                    chk("hold_ovf4", 64'(ovf4), 64'(ho4));
                end
                prev_v = valid30 | valid4;
            end
        end
    end

    task automatic step(input bit t, input bit e);
        @(negedge clk_i);
        tick_i = t;
        en_i   = e;
    endtask

    task automatic pulses(input int p, input int n, input int hi);
        repeat (n) for (int i = 0; i < p; i++) step(i < hi, 1'b1);
    endtask

    initial begin
        int drop;
        // Reset held while tick_i toggles.
        for (int i = 0; i < 8; i++) step(i[0], 1'b1);
        @(negedge clk_i);
        rst_ni = 1'b1;
        pulses(5, 6, 1);

        // Tick-generator loopback: k=4 then k=9.
        pulses(5, 6, 1);
        pulses(10, 6, 1);

        // Overflow for the narrow meter, then back under range.
        pulses(20, 4, 3);
        pulses(6, 5, 2);

        // Enable drop for 3 cycles covering a detected edge.
        pulses(8, 3, 1);
        step(1'b1, 1'b1);
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        repeat (4) step(1'b0, 1'b1);
        pulses(8, 4, 1);

        // Minimum period: toggle every cycle.
        pulses(2, 12, 1);

        // Async reset mid-measurement.
        pulses(7, 3, 2);
        repeat (3) step(1'b0, 1'b1);
        @(posedge clk_i);
        #3;
        rst_ni = 1'b0;
        q.delete();
        #1;
        chk("async_rst_period30", 64'(period30), 0);
        chk("async_rst_period4", 64'(period4), 0);
        chk("async_rst_valid", 64'({valid30, valid4}), 0);
        chk("async_rst_ovf", 64'({ovf30, ovf4}), 0);
        repeat (2) step(1'b1, 1'b1);
        rst_ni = 1'b1;
        pulses(7, 4, 2);

        // Random periods, widths and enable drops.
        drop = 0;
        repeat (40) begin
            int p, hi, n;
            p  = $urandom_range(2, 40);
            hi = $urandom_range(1, p - 1);
            n  = $urandom_range(1, 4);
            repeat (n) for (int i = 0; i < p; i++) begin
                if (drop == 0 && $urandom_range(0, 59) == 0) drop = $urandom_range(1, 5);
                step(i < hi, drop == 0);
                if (drop > 0) drop--;
            end
        end

        repeat (6) step(1'b0, 1'b1);
        chk("queue_drained", 64'(q.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
